uart_program_memory: RTL
========================

Name: uart_program_memory

Overview:
- Parametrised instruction memory that loads its contents from a framed UART byte stream. It generalises the fixed 32x16 loader to configurable instruction width and depth.
- New capabilities over the fixed loader: sync/length header, checksum, inter-byte timeout, reload and error reporting.
- Sits between the board UART receiver (rxuartlite, instantiated at top level) and the CPU fetch stage; the CPU is held off until load_done.

Parameters:
- INSTR_WIDTH, 16, instruction width in bits; must be a multiple of 8, range 8..64.
- DEPTH, 32, number of instruction words; power of two, range 2..4096.
- ADDR_W, $clog2(DEPTH), localparam, program-counter width.
- BYTES_PER_WORD, INSTR_WIDTH/8, localparam.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle strobe, byte available (rxuartlite o_wr).
- rx_data  input  8  received byte (rxuartlite o_data).
- reload  input  1  one-cycle pulse, discard the current state and await a new frame.
- program_counter  input  ADDR_W  fetch address.
- instruction  output  INSTR_WIDTH  registered read data.
- load_done  output  1  program loaded and checksum good.
- load_error  output  1  last frame rejected.
- loading  output  1  frame in progress (state not IDLE/DONE/ERROR).
- word_count  output  16  length field of the last accepted header.

Behaviour:
- Reset (async, RST_N=0): state IDLE, load_done=0, load_error=0, loading=0, word_count=0, instruction=0, internal counters 0. Memory array is not cleared.
- Read port: instruction <= mem[program_counter] every cycle, 1-cycle latency, independent of loader state. Read-during-write to the same address returns old data.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then LEN words of BYTES_PER_WORD bytes each (MSB first), then CSUM. CSUM is the 8-bit modulo-256 sum of the data bytes only.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR. Transitions occur only on rx_valid except for timeout and reload.
- IDLE: byte==SYNC_BYTE -> LEN_HI; any other byte is ignored.
- LEN_HI: store high byte -> LEN_LO.
- LEN_LO: form LEN. If LEN==0 or LEN>DEPTH -> ERROR. Otherwise word_count<=LEN, write address 0, byte index 0, sum 0 -> DATA.
- DATA: shift the byte into the assembly register and add it to the sum. When the last byte of a word arrives, write the assembled word to mem[addr] on that same edge and increment addr. After word LEN-1 -> CSUM.
- CSUM: byte==sum -> DONE; otherwise -> ERROR. Flags update on that edge, visible the next cycle.
- DONE: load_done=1, load_error=0. All bytes are ignored; only reload leaves this state.
- ERROR: load_error=1, load_done=0. Behaves as IDLE: a SYNC_BYTE clears load_error and goes to LEN_HI.
- Timeout: counter clears on every accepted byte and runs in LEN_HI/LEN_LO/DATA/CSUM. Reaching TIMEOUT_CYCLES -> ERROR.
- Partial load: words written before an error or timeout stay in memory. Addresses >= LEN keep their prior contents.
- reload (any state): -> IDLE, load_done=0, load_error=0. If rx_valid arrives in the same cycle, reload wins and the byte is dropped.
- Reset mid-frame: immediate IDLE. A later frame must start with SYNC_BYTE.

Decomposition:
- Shared package: loader FSM state encoding, SYNC_BYTE default, max frame length constant.
- No sub-module is needed. The UART receiver stays external so the block is testable with a byte-stream driver.

Test Plan:
- Good load: defaults; bytes A5 00 02 12 34 AB CD BE -> load_done=1 one cycle after BE. pc=0 gives 0x1234; pc=1 gives 0xABCD on the next cycle; word_count=2.
- Bad length: A5 00 21 -> load_error=1 after the third byte, loading=0. A following good frame clears load_error and loads.
- Bad checksum: A5 00 01 00 07 08 -> load_error=1, load_done=0. mem[0] reads 0x0007 (partial data retained).
- Timeout: TIMEOUT_CYCLES=100; send A5 00 01 00, then idle -> load_error=1 exactly 100 cycles after the last byte.
- Reload: after the good load, pulse reload, then A5 00 01 55 66 BB -> mem[0]=0x5566, mem[1] still 0xABCD. Bytes sent in DONE without reload are ignored.
- Width/reset: INSTR_WIDTH=24, DEPTH=8; frame A5 00 01 01 02 03 06 -> mem[0]=0x010203. Assert RST_N mid-frame -> all flags 0, state IDLE.

Source files
------------

// File: rtl/uart_program_memory_pkg.sv
// Shared definitions for the UART-loaded program memory: loader state
// encoding, frame constants and a small state classification helper.
package uart_program_memory_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_e;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int unsigned MAX_FRAME_LEN     = 4096;

  // True while a frame is being received (timeout window and loading flag).
  function automatic logic is_loading(input loader_state_e s);
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_program_memory.sv
// Instruction memory filled from a framed UART byte stream
// (sync, 16-bit length, MSB-first words, 8-bit additive checksum).
module uart_program_memory
  import uart_program_memory_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH    = 16,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  localparam int unsigned ADDR_W         = $clog2(DEPTH),
  localparam int unsigned BYTES_PER_WORD = INSTR_WIDTH / 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   reload,
  input  logic [ADDR_W-1:0]      program_counter,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   load_done,
  output logic                   load_error,
  output logic                   loading,
  output logic [15:0]            word_count
);

  localparam int unsigned   TMR_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   DEPTH_L   = 17'(DEPTH);
  localparam logic [3:0]    LAST_BYTE = 4'(BYTES_PER_WORD - 1);

  loader_state_e          state_r, state_nxt_s;
  logic [7:0]             len_hi_r, len_hi_nxt_s;
  logic [15:0]            word_count_r, word_count_nxt_s;
  logic [15:0]            word_idx_r, word_idx_nxt_s;
  logic [3:0]             byte_idx_r, byte_idx_nxt_s;
  logic [7:0]             sum_r, sum_nxt_s;
  logic [INSTR_WIDTH-1:0] asm_r, asm_nxt_s;
  logic [TMR_W-1:0]       timer_r, timer_nxt_s;
  logic                   done_r, done_nxt_s;
  logic                   error_r, error_nxt_s;
  logic                   loading_r;
  logic [INSTR_WIDTH-1:0] instruction_r;
  logic                   mem_we_s;
  logic [15:0]            len_s;
  logic                   timeout_s;

  logic [INSTR_WIDTH-1:0] mem_r [DEPTH];

  assign len_s     = {len_hi_r, rx_data};
  assign timeout_s = (timer_r == TMR_LIMIT);

  // Loader next-state, datapath next values and memory write strobe.
  always_comb begin
    state_nxt_s      = state_r;
    len_hi_nxt_s     = len_hi_r;
    word_count_nxt_s = word_count_r;
    word_idx_nxt_s   = word_idx_r;
    byte_idx_nxt_s   = byte_idx_r;
    sum_nxt_s        = sum_r;
    asm_nxt_s        = asm_r;
    done_nxt_s       = done_r;
    error_nxt_s      = error_r;
    mem_we_s         = 1'b0;
    timer_nxt_s      = '0;

    if (!reload && !rx_valid && is_loading(state_r) && !timeout_s) begin
      timer_nxt_s = timer_r + TMR_W'(1);
    end else begin
      timer_nxt_s = '0;
    end

    if (reload) begin
      state_nxt_s = ST_IDLE;
      done_nxt_s  = 1'b0;
      error_nxt_s = 1'b0;
    end else if (!rx_valid && timeout_s && is_loading(state_r)) begin
      state_nxt_s = ST_ERROR;
      done_nxt_s  = 1'b0;
      error_nxt_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_ERROR: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_nxt_s = ST_LEN_HI;
            error_nxt_s = 1'b0;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            len_hi_nxt_s = rx_data;
            state_nxt_s  = ST_LEN_LO;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_LEN_LO: begin
          if (rx_valid && ((len_s == 16'd0) || ({1'b0, len_s} > DEPTH_L))) begin
            state_nxt_s = ST_ERROR;
            done_nxt_s  = 1'b0;
            error_nxt_s = 1'b1;
          end else if (rx_valid) begin
            word_count_nxt_s = len_s;
            word_idx_nxt_s   = 16'd0;
            byte_idx_nxt_s   = 4'd0;
            sum_nxt_s        = 8'd0;
            state_nxt_s      = ST_DATA;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            sum_nxt_s = sum_r + rx_data;
            asm_nxt_s = (asm_r << 8) | INSTR_WIDTH'(rx_data);
            if (byte_idx_r == LAST_BYTE) begin
              mem_we_s       = 1'b1;
              byte_idx_nxt_s = 4'd0;
              word_idx_nxt_s = word_idx_r + 16'd1;
              if (word_idx_r == (word_count_r - 16'd1)) begin
                state_nxt_s = ST_CSUM;
              end else begin
                state_nxt_s = ST_DATA;
              end
            end else begin
              byte_idx_nxt_s = byte_idx_r + 4'd1;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_CSUM: begin
          if (rx_valid && (rx_data == sum_r)) begin
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
            error_nxt_s = 1'b0;
          end else if (rx_valid) begin
            state_nxt_s = ST_ERROR;
            done_nxt_s  = 1'b0;
            error_nxt_s = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Loader state and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= ST_IDLE;
      len_hi_r     <= 8'd0;
      word_count_r <= 16'd0;
      word_idx_r   <= 16'd0;
      byte_idx_r   <= 4'd0;
      sum_r        <= 8'd0;
      asm_r        <= '0;
      timer_r      <= '0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      loading_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      len_hi_r     <= len_hi_nxt_s;
      word_count_r <= word_count_nxt_s;
      word_idx_r   <= word_idx_nxt_s;
      byte_idx_r   <= byte_idx_nxt_s;
      sum_r        <= sum_nxt_s;
      asm_r        <= asm_nxt_s;
      timer_r      <= timer_nxt_s;
      done_r       <= done_nxt_s;
      error_r      <= error_nxt_s;
      loading_r    <= is_loading(state_nxt_s);
    end
  end

  // Memory array write; contents survive reset so a partial load stays visible.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_r[word_idx_r[ADDR_W-1:0]] <= asm_nxt_s;
    end
  end

  // Registered fetch port; same-address write in this cycle returns old data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instruction_r <= '0;
    end else begin
      instruction_r <= mem_r[program_counter];
    end
  end

  assign instruction = instruction_r;
  assign load_done   = done_r;
  assign load_error  = error_r;
  assign loading     = loading_r;
  assign word_count  = word_count_r;

endmodule
